// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared AXI response codes and prefetch buffer entry layout
package ifu_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Buffer entry for the default 32-bit address / 32-bit instruction configuration
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - flushable synchronous FIFO holding fetched instruction entries
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1),
  localparam int PW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a push
  assign do_push  = push && (!full || do_pop);
  // Head is forced to zero when nothing is buffered so the outputs are quiet
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy update; flush discards everything, including a same-cycle push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; no reset needed because the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential AXI4-Lite instruction prefetcher with redirect flush
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_ins,
  output logic                  out_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int                    CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] ins;
    logic                  err;
  } entry_t;

  logic                  run;         // first cycle after reset release onwards
  logic                  ar_pend;     // AR shown last cycle and not accepted
  logic                  ar_stale;    // held AR belongs to the pre-redirect stream
  logic [ADDR_WIDTH-1:0] stale_addr;  // address of that held stale AR
  logic [ADDR_WIDTH-1:0] fetch_pc;    // next address to request on the live stream
  logic [ADDR_WIDTH-1:0] resp_pc;     // PC of the next non-dropped response
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  credit_ok;
  logic                  ar_hs;
  logic                  ar_hold;
  logic                  r_hs;
  logic                  keep;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_base;
  entry_t                push_entry;
  entry_t                head;

  // Buffered words plus outstanding reads never exceed the buffer, so every response has a slot
  assign credit_ok     = !fifo_full &&
                         (({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
  assign arvalid       = run && (ar_pend || (credit_ok && !redirect_valid));
  assign araddr        = ar_stale ? stale_addr : fetch_pc;
  assign rready        = run;
  assign ar_hs         = arvalid && arready;
  assign ar_hold       = arvalid && !arready;
  assign r_hs          = rvalid && rready;
  assign keep          = r_hs && (drop == '0);
  assign pop           = out_valid && out_ready;
  assign redirect_base = redirect_pc & ~(STEP_A - ADDR_WIDTH'(1));
  assign push_entry    = '{pc: resp_pc, ins: rdata, err: (rresp != RESP_OKAY)};

  assign out_valid = !fifo_empty;
  assign out_pc    = head.pc;
  assign out_ins   = head.ins;
  assign out_err   = head.err;

  // Request address, outstanding/drop accounting and response PC tagging
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      ar_pend    <= 1'b0;
      ar_stale   <= 1'b0;
      stale_addr <= RESET_PC;
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      inflight   <= '0;
      drop       <= '0;
    end else begin
      run      <= 1'b1;
      ar_pend  <= ar_hold;
      inflight <= inflight + CW'(ar_hs) - CW'(r_hs);
      if (redirect_valid) begin
        // Everything still owed by memory, plus a held AR, belongs to the old stream
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        drop     <= inflight + CW'(ar_hs) - CW'(r_hs) + CW'(ar_hold);
        ar_stale <= ar_hold;
        if (ar_hold) stale_addr <= araddr;
      end else begin
        if (ar_hs && !ar_stale) fetch_pc <= fetch_pc + STEP_A;
        if (ar_hs)              ar_stale <= 1'b0;
        if (keep)               resp_pc  <= resp_pc + STEP_A;
        if (r_hs && drop != '0) drop     <= drop - CW'(1);
      end
    end
  end

  ifu_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - randomized self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        out_valid, out_err, arvalid, rready;
  logic [31:0] out_pc, out_ins, araddr;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] w_pc[$], w_ins[$], e_pc[$], e_ins[$], w_ar[$];
  logic        w_err[$], e_err[$];
  logic [31:0] m_next_pc = RESET_PC;
  logic [31:0] err_pc = 32'hFFFF_FFFF;
  logic [31:0] redir_target = '0;
  logic        redir_req = 1'b0;
  int          cyc = 0, max_out = 0;
  int          ready_pct = 100, oready_pct = 100, lat_min = 1, lat_max = 1;
  int          n_checks = 0, n_fail = 0;

  ifu_prefetch dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .out_err(out_err), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // Memory content is a fixed scramble of the address
  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive memory/decode/redirect inputs, then log handshakes and the expected stream
  task automatic tick();
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    arready   = ($urandom_range(99) < ready_pct);
    out_ready = ($urandom_range(99) < oready_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = ins_of(mem_q[0].addr);
      rresp  = (mem_q[0].addr == err_pc) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = 2'b00;
    end
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    redir_req      = 1'b0;
    #1;
    if (rvalid && rready) void'(mem_q.pop_front());
    if (arvalid && arready) begin
      r.addr = araddr;
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      mem_q.push_back(r);
      w_ar.push_back(araddr);
    end
    if (mem_q.size() > max_out) max_out = mem_q.size();
    if (out_valid && out_ready) begin
      w_pc.push_back(out_pc);
      w_ins.push_back(out_ins);
      w_err.push_back(out_err);
      e_pc.push_back(m_next_pc);
      e_ins.push_back(ins_of(m_next_pc));
      e_err.push_back(m_next_pc == err_pc);
      m_next_pc = m_next_pc + 32'd4;
    end
    if (redirect_valid) m_next_pc = redir_target & ~32'h3;
  endtask

  task automatic clear_model();
    mem_q.delete(); w_pc.delete(); w_ins.delete(); w_err.delete(); w_ar.delete();
    e_pc.delete(); e_ins.delete(); e_err.delete();
    m_next_pc = RESET_PC;
    max_out   = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redir_req = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b exp 0", arvalid); end
    n_checks++; if (araddr !== RESET_PC) begin n_fail++; $display("FAIL reset_araddr got %h exp %h", araddr, RESET_PC); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got %b exp 0", rready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if ({out_pc, out_ins, out_err} !== 65'd0) begin n_fail++; $display("FAIL reset_out_word got %h %h %b exp 0", out_pc, out_ins, out_err); end
    rst_n = 1'b1;
    clear_model();
    tick();
    n_checks++; if (arvalid !== 1'b1 || araddr !== RESET_PC) begin n_fail++; $display("FAIL first_ar got v=%b a=%h exp v=1 a=%h", arvalid, araddr, RESET_PC); end
    n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL run_rready got %b exp 1", rready); end
  endtask

  task automatic test_stream();
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (40) tick();
    n_checks++; if (w_pc.size() < 34) begin n_fail++; $display("FAIL stream_throughput got %0d words exp >=34", w_pc.size()); end
    n_checks++; if (max_out > 4) begin n_fail++; $display("FAIL stream_outstanding got %0d exp <=4", max_out); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL stream_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    ready_pct = 100; oready_pct = 0; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (10) tick();
    n_checks++; if (w_ar.size() != 4) begin n_fail++; $display("FAIL bp_ar_count got %0d exp 4", w_ar.size()); end
    n_checks++; if (arvalid !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall got arvalid=%b out_valid=%b exp 0/1", arvalid, out_valid); end
    oready_pct = 100;
    repeat (15) tick();
    n_checks++; if (w_pc.size() < 12) begin n_fail++; $display("FAIL bp_release got %0d words exp >=12", w_pc.size()); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL bp_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
  endtask

  task automatic test_redirect_latency();
    int k = 0;
    int n_before;
    ready_pct = 100; oready_pct = 100; lat_min = 5; lat_max = 5;
    do_reset();
    while (mem_q.size() != 3 && k < 20) begin tick(); k++; end
    n_checks++; if (mem_q.size() != 3) begin n_fail++; $display("FAIL redir_wait got %0d in flight exp 3", mem_q.size()); end
    redir_req = 1'b1; redir_target = 32'h8000_0100;
    tick();
    n_before = w_pc.size();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_out_valid got %b exp 0", out_valid); end
    repeat (30) tick();
    n_checks++; if (w_pc.size() < n_before + 10) begin n_fail++; $display("FAIL redir_count got %0d exp >=%0d", w_pc.size(), n_before + 10); end
    n_checks++; if (w_pc.size() <= n_before || w_pc[n_before] !== 32'h8000_0100) begin n_fail++; $display("FAIL redir_first_pc got %h exp 80000100", (w_pc.size() > n_before) ? w_pc[n_before] : 32'hx); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL redir_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
  endtask

  task automatic test_held_redirect();
    ready_pct = 0; oready_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (3) tick();
    n_checks++; if (arvalid !== 1'b1 || araddr !== RESET_PC) begin n_fail++; $display("FAIL held_pending got v=%b a=%h exp 1/%h", arvalid, araddr, RESET_PC); end
    redir_req = 1'b1; redir_target = 32'h8000_0102;
    tick();
    tick();
    n_checks++; if (arvalid !== 1'b1 || araddr !== RESET_PC) begin n_fail++; $display("FAIL held_after_redirect got v=%b a=%h exp 1/%h", arvalid, araddr, RESET_PC); end
    ready_pct = 100;
    repeat (20) tick();
    n_checks++; if (w_ar.size() < 2 || w_ar[0] !== RESET_PC || w_ar[1] !== 32'h8000_0100) begin n_fail++; $display("FAIL held_ar_order got %0d ARs first %h exp %h then 80000100", w_ar.size(), (w_ar.size() > 0) ? w_ar[0] : 32'hx, RESET_PC); end
    n_checks++; if (w_pc.size() < 10 || w_pc[0] !== 32'h8000_0100) begin n_fail++; $display("FAIL held_first_word got %0d words first %h exp 80000100", w_pc.size(), (w_pc.size() > 0) ? w_pc[0] : 32'hx); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL held_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
  endtask

  task automatic test_error();
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 2;
    err_pc = 32'h8000_0004;
    do_reset();
    repeat (20) tick();
    n_checks++; if (w_pc.size() < 8 || w_err[0] !== 1'b0 || w_err[1] !== 1'b1 || w_err[2] !== 1'b0) begin n_fail++; $display("FAIL err_flags got %0d words err0..2=%b%b%b exp 010", w_pc.size(), w_err[0], w_err[1], w_err[2]); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL err_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
    err_pc = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset_mid();
    ready_pct = 100; oready_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (8) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (arvalid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got arvalid=%b out_valid=%b exp 0/0", arvalid, out_valid); end
    do_reset();
    repeat (12) tick();
    n_checks++; if (w_pc.size() < 8 || w_pc[0] !== RESET_PC) begin n_fail++; $display("FAIL mid_restart got %0d words first %h exp %h", w_pc.size(), (w_pc.size() > 0) ? w_pc[0] : 32'hx, RESET_PC); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL mid_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
  endtask

  task automatic test_random();
    ready_pct = 70; oready_pct = 70; lat_min = 1; lat_max = 4;
    err_pc = 32'h8000_0010;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(99) < 3) begin
        redir_req    = 1'b1;
        redir_target = 32'h8000_0000 | $urandom_range(32'h3FF);
      end
      tick();
    end
    n_checks++; if (w_pc.size() < 100) begin n_fail++; $display("FAIL rand_progress got %0d words exp >=100", w_pc.size()); end
    n_checks++; if (max_out > 4) begin n_fail++; $display("FAIL rand_outstanding got %0d exp <=4", max_out); end
    for (int i = 0; i < w_pc.size(); i++) begin
      n_checks++;
      if (w_pc[i] !== e_pc[i] || w_ins[i] !== e_ins[i] || w_err[i] !== e_err[i]) begin
        n_fail++; $display("FAIL rand_word[%0d] got %h/%h/%b exp %h/%h/%b", i, w_pc[i], w_ins[i], w_err[i], e_pc[i], e_ins[i], e_err[i]);
      end
    end
    err_pc = 32'hFFFF_FFFF;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_held_redirect();
    test_error();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
